// File: rtl/vga_pixel_fetch_pkg.sv
// vga_pixel_fetch_pkg: shared constants and colour type for the VGA pixel path
package vga_pixel_fetch_pkg;
  localparam int FETCH_WORD_W = 16;
  localparam int PIX_PER_WORD_SHIFT = 4;
  localparam int SCALE_SHIFT = 1;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth register pipe with a programmable reset value
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];
  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_q <= '{default: RST_VAL};
    else pipe_q <= pipe_d;
  assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: fetches 1-bpp frame-buffer words and renders them 2x scaled onto the VGA pixel stream
module vga_pixel_fetch
  import vga_pixel_fetch_pkg::*;
#(
  parameter int SRC_W      = 512,
  parameter int SRC_H      = 300,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 14
) (
  input  logic              VIDEO_CLK,
  input  logic              RESET_N,
  input  logic [11:0]       X_IN,
  input  logic [11:0]       Y_IN,
  input  logic              VISIBLE_IN,
  input  logic              HS_IN,
  input  logic              VS_IN,
  input  logic [23:0]       FG_RGB,
  input  logic [23:0]       BG_RGB,
  input  logic [23:0]       BORDER_RGB,
  input  logic [23:0]       ERR_RGB,
  input  logic              CLEAR_ERR,
  output logic              MEM_RD,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [15:0]       MEM_RDATA,
  input  logic              MEM_RVALID,
  output logic [23:0]       RGB_OUT,
  output logic              HS_OUT,
  output logic              VS_OUT,
  output logic              VISIBLE_OUT,
  output logic              UNDERRUN
);
  localparam int PIPE = RD_LATENCY + 2;
  localparam int WORDS_PER_LINE = SRC_W >> PIX_PER_WORD_SHIFT;
  localparam logic [11:0] W_LIM = 12'(SRC_W);
  localparam logic [11:0] H_LIM = 12'(SRC_H);
  localparam int FW = 2 + PIX_PER_WORD_SHIFT;
  logic [11:0] sx, sy;
  logic in_win, fetch, exp_tap, f_vis, f_win;
  logic [PIX_PER_WORD_SHIFT-1:0] f_idx;
  logic [2:0] sync_q;
  logic mem_rd_q, mem_rd_d, err_q, err_d, und_q, und_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [FETCH_WORD_W-1:0] word_q, word_d;
  rgb24_t rgb_q, rgb_d;
  assign sx = X_IN >> SCALE_SHIFT;
  assign sy = Y_IN >> SCALE_SHIFT;
  always_comb begin
    in_win = VISIBLE_IN && sx < W_LIM && sy < H_LIM;
    fetch = in_win && X_IN[4:0] == '0;
    mem_rd_d = fetch;
    mem_addr_d = fetch ? ADDR_W'(sy) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(sx >> PIX_PER_WORD_SHIFT) : mem_addr_q;
    word_d = exp_tap && MEM_RVALID ? MEM_RDATA : word_q;
    err_d = exp_tap ? !MEM_RVALID : err_q;
    und_d = (exp_tap && !MEM_RVALID) || (und_q && !CLEAR_ERR);
    // the bypassed word_d lets the first pixel of a word render in the cycle its data arrives
    rgb_d = !f_vis ? '0 : !f_win ? BORDER_RGB : err_d ? ERR_RGB :
            word_d[PIX_PER_WORD_SHIFT'(FETCH_WORD_W - 1) - f_idx] ? FG_RGB : BG_RGB;
  end
  always_ff @(posedge VIDEO_CLK or negedge RESET_N)
    if (!RESET_N) begin
      mem_rd_q <= 1'b0;
      mem_addr_q <= '0;
      word_q <= '0;
      err_q <= 1'b0;
      und_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      mem_rd_q <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      word_q <= word_d;
      err_q <= err_d;
      und_q <= und_d;
      rgb_q <= rgb_d;
    end
  vga_delay_line #(.WIDTH(3), .DEPTH(PIPE), .RST_VAL(3'b100)) u_sync (
    .clk(VIDEO_CLK), .rst_n(RESET_N), .d({HS_IN, VS_IN, VISIBLE_IN}), .q(sync_q)
  );
  vga_delay_line #(.WIDTH(FW), .DEPTH(PIPE - 1), .RST_VAL('0)) u_flags (
    .clk(VIDEO_CLK), .rst_n(RESET_N),
    .d({VISIBLE_IN, in_win, sx[PIX_PER_WORD_SHIFT-1:0]}), .q({f_vis, f_win, f_idx})
  );
  vga_delay_line #(.WIDTH(1), .DEPTH(RD_LATENCY), .RST_VAL(1'b0)) u_expect (
    .clk(VIDEO_CLK), .rst_n(RESET_N), .d(mem_rd_q), .q(exp_tap)
  );
  assign {HS_OUT, VS_OUT, VISIBLE_OUT} = sync_q;
  assign MEM_RD = mem_rd_q;
  assign MEM_ADDR = mem_addr_q;
  assign RGB_OUT = rgb_q;
  assign UNDERRUN = und_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: directed and randomized scan checks against a frame-buffer reference model
module tb_vga_pixel_fetch;
  localparam int L = 2;
  localparam int PIPE = L + 2;
  typedef struct {
    logic [23:0] rgb;
    logic hs, vs, vis, set;
  } exp_t;
  typedef struct {
    logic rd;
    logic [13:0] addr;
    logic drop;
  } req_t;
  logic clk = 0, RESET_N, VISIBLE_IN, HS_IN, VS_IN, CLEAR_ERR, MEM_RVALID;
  logic [11:0] X_IN, Y_IN;
  logic [23:0] FG_RGB, BG_RGB, BORDER_RGB, ERR_RGB;
  logic [15:0] MEM_RDATA;
  logic MEM_RD, HS_OUT, VS_OUT, VISIBLE_OUT, UNDERRUN;
  logic [13:0] MEM_ADDR;
  logic [23:0] RGB_OUT;
  exp_t eq[$];
  req_t mq[$];
  logic [15:0] mem [9600];
  logic [15:0] cur_word;
  logic cur_err, und_exp, prev_fetch, prev_drop, prev_clr;
  logic [13:0] prev_addr;
  int checks = 0, errors = 0;
  vga_pixel_fetch dut (
    .VIDEO_CLK(clk), .RESET_N(RESET_N), .X_IN(X_IN), .Y_IN(Y_IN), .VISIBLE_IN(VISIBLE_IN),
    .HS_IN(HS_IN), .VS_IN(VS_IN), .FG_RGB(FG_RGB), .BG_RGB(BG_RGB), .BORDER_RGB(BORDER_RGB),
    .ERR_RGB(ERR_RGB), .CLEAR_ERR(CLEAR_ERR), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR),
    .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID), .RGB_OUT(RGB_OUT), .HS_OUT(HS_OUT),
    .VS_OUT(VS_OUT), .VISIBLE_OUT(VISIBLE_OUT), .UNDERRUN(UNDERRUN)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // frame-buffer model: answers each observed read L cycles later, optionally withholding valid
  task automatic mem_respond();
    req_t r;
    r.rd = MEM_RD;
    r.addr = MEM_ADDR;
    r.drop = prev_drop;
    mq.push_back(r);
    r = mq.pop_front();
    if (r.rd === 1'b1) begin
      MEM_RVALID = !r.drop;
      MEM_RDATA = r.drop ? 16'($urandom) : mem[r.addr];
    end else begin
      MEM_RVALID = ($urandom_range(0, 3) == 0);
      MEM_RDATA = 16'($urandom);
    end
  endtask
  task automatic step(input logic vis, input logic [11:0] x, input logic [11:0] y,
                      input logic hs, input logic vs, input logic drop, input logic clr);
    exp_t e;
    logic [11:0] sx, sy;
    logic win, fetch;
    logic [13:0] addr;
    @(negedge clk);
    e = eq.pop_front();
    und_exp = e.set ? 1'b1 : prev_clr ? 1'b0 : und_exp;
    chk("rgb", RGB_OUT, e.rgb);
    chk("hs", 24'(HS_OUT), 24'(e.hs));
    chk("vs", 24'(VS_OUT), 24'(e.vs));
    chk("visible", 24'(VISIBLE_OUT), 24'(e.vis));
    chk("underrun", 24'(UNDERRUN), 24'(und_exp));
    chk("mem_rd", 24'(MEM_RD), 24'(prev_fetch));
    if (prev_fetch) chk("mem_addr", 24'(MEM_ADDR), 24'(prev_addr));
    mem_respond();
    VISIBLE_IN = vis; X_IN = x; Y_IN = y; HS_IN = hs; VS_IN = vs; CLEAR_ERR = clr;
    sx = x / 2;
    sy = y / 2;
    win = vis && sx < 512 && sy < 300;
    fetch = win && (x % 32 == 0);
    addr = 0;
    if (fetch) begin
      addr = 14'(sy * 32 + sx / 16);
      cur_word = mem[addr];
      cur_err = drop;
    end
    e.rgb = !vis ? 24'h0 : !win ? BORDER_RGB : cur_err ? ERR_RGB :
            cur_word[15 - int'(sx % 16)] ? FG_RGB : BG_RGB;
    e.hs = hs; e.vs = vs; e.vis = vis; e.set = fetch && drop;
    eq.push_back(e);
    prev_fetch = fetch; prev_addr = addr; prev_drop = fetch && drop; prev_clr = clr;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 12'($urandom), 12'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic async_reset();
    @(negedge clk);
    mem_respond();
    #1 RESET_N = 0;
    #1;
    chk("rst_mem_rd", 24'(MEM_RD), 24'h0);
    chk("rst_mem_addr", 24'(MEM_ADDR), 24'h0);
    chk("rst_rgb", RGB_OUT, 24'h0);
    chk("rst_visible", 24'(VISIBLE_OUT), 24'h0);
    chk("rst_underrun", 24'(UNDERRUN), 24'h0);
    chk("rst_hs", 24'(HS_OUT), 24'h1);
    chk("rst_vs", 24'(VS_OUT), 24'h0);
    VISIBLE_IN = 0; HS_IN = 1; VS_IN = 0; CLEAR_ERR = 0;
    #1 RESET_N = 1;
    eq.delete();
    repeat (PIPE) eq.push_back('{rgb: 24'h0, hs: 1'b1, vs: 1'b0, vis: 1'b0, set: 1'b0});
    cur_word = 0; cur_err = 0; und_exp = 0;
    prev_fetch = 0; prev_drop = 0; prev_clr = 0; prev_addr = 0;
  endtask
  initial begin
    logic [11:0] y, x0;
    logic hs, vs;
    int n;
    RESET_N = 1; VISIBLE_IN = 0; X_IN = 0; Y_IN = 0; HS_IN = 1; VS_IN = 0; CLEAR_ERR = 0;
    MEM_RDATA = 0; MEM_RVALID = 0;
    FG_RGB = 24'hF0E0D0; BG_RGB = 24'h102030; BORDER_RGB = 24'h00AA55; ERR_RGB = 24'hFF0000;
    for (int i = 0; i < 9600; i++) mem[i] = 16'($urandom);
    repeat (L) mq.push_back('{rd: 1'b0, addr: 14'h0, drop: 1'b0});
    prev_drop = 0;
    async_reset();
    mem[0] = 16'h8000;
    for (int i = 0; i < 64; i++) step(1'b1, 12'(i), 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    step(1'b1, 12'd992, 12'd599, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("addr_9599_rd", 24'(MEM_RD), 24'h1);
    chk("addr_9599", 24'(MEM_ADDR), 24'd9599);
    idle(6);
    for (int i = 0; i < 1056; i++) step(1'b1, 12'(i), 12'd599, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 104; i++) step(1'b0, 12'($urandom), 12'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 40; i++) step(1'b0, 12'($urandom), 12'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 64; i++) step(1'b1, 12'(i), 12'd600, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 96; i++) step(1'b1, 12'(i), 12'd20, 1'b1, 1'b0, i == 32, 1'b0);
    idle(6);
    chk("underrun_set", 24'(UNDERRUN), 24'h1);
    for (int i = 0; i < 128; i++) step(1'b1, 12'(i), 12'd22, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 12'd5, 12'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("underrun_clear", 24'(UNDERRUN), 24'h0);
    for (int i = 0; i < 40; i++) step(1'b1, 12'(i), 12'd30, 1'b1, 1'b0, i == 0, i == PIPE - 1);
    idle(4);
    chk("underrun_set_wins", 24'(UNDERRUN), 24'h1);
    step(1'b0, 12'd5, 12'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);
    mem[162] = 16'hFFFF;
    step(1'b1, 12'd64, 12'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    async_reset();
    idle(4);
    step(1'b1, 12'd2, 12'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    step(1'b1, 12'd64, 12'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    async_reset();
    idle(10);
    for (int s = 0; s < 40; s++) begin
      y = 12'($urandom_range(0, 640));
      x0 = 12'(32 * $urandom_range(0, 36));
      n = 32 * $urandom_range(1, 4);
      hs = 1'($urandom); vs = 1'($urandom);
      for (int i = 0; i < n; i++)
        step(1'b1, x0 + 12'(i), y, hs, vs, (i % 32 == 0) && ($urandom_range(0, 5) == 0), 1'b0);
      idle($urandom_range(1, 6));
    end
    idle(PIPE + 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
